// File: rtl/aes_pkg.sv
// Shared AES types, FSM encoding and byte-level helpers (S-box, Rcon, xtime, SubWord).
package aes_pkg;

    typedef logic [127:0] aes_state_t;
    typedef logic [31:0]  aes_word_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_KEXP  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } aes_fsm_t;

    // Index 0 is the most significant byte of the concatenation.
    localparam logic [0:255][7:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:9][7:0] RCON_TBL = 80'h01020408102040801b36;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[b];
    endfunction

    // Rcon is indexed 1..10 as in the key schedule.
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] v;
        v = 8'h00;
        if (idx >= 4'd1 && idx <= 4'd10) begin
            v = RCON_TBL[idx - 4'd1];
        end
        return v;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic aes_word_t sub_word(input aes_word_t w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic int nk_of(input int key_bits);
        return key_bits / 32;
    endfunction

    function automatic int nr_of(input int key_bits);
        return key_bits / 32 + 6;
    endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns (skipped on the
// final round) and AddRoundKey. Byte k of the state is bits [127-8k -: 8].
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [127:0] i_rkey,
    input  logic         i_last,
    output logic [127:0] o_state
);

    logic [7:0] w_sb [16];
    logic [7:0] w_sr [16];
    logic [7:0] w_mc [16];

    for (genvar k = 0; k < 16; k++) begin : g_sub
        assign w_sb[k] = sbox(i_state[127-8*k -: 8]);
    end

    // Byte 4c+r sits at row r, column c; row r rotates left by r columns.
    for (genvar c = 0; c < 4; c++) begin : g_shift_col
        for (genvar r = 0; r < 4; r++) begin : g_shift_row
            assign w_sr[4*c+r] = w_sb[4*((c+r)%4)+r];
        end
    end

    for (genvar c = 0; c < 4; c++) begin : g_mix
        logic [7:0] w_a0, w_a1, w_a2, w_a3;
        assign w_a0 = w_sr[4*c];
        assign w_a1 = w_sr[4*c+1];
        assign w_a2 = w_sr[4*c+2];
        assign w_a3 = w_sr[4*c+3];
        assign w_mc[4*c]   = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
        assign w_mc[4*c+1] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
        assign w_mc[4*c+2] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
        assign w_mc[4*c+3] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
    end

    for (genvar k = 0; k < 16; k++) begin : g_ark
        assign o_state[127-8*k -: 8] = (i_last ? w_sr[k] : w_mc[k]) ^ i_rkey[127-8*k -: 8];
    end

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES encryptor, one round per clock; the key schedule is expanded once
// into a word store and reused for every block until the next key_load.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for key_load (priority) or a plaintext handshake
//   ST_KEXP  | writing one schedule word per cycle, w[NK] .. w[NW-1]
//   ST_ROUND | applying round r = 1..NR to the block state
//   ST_DONE  | ciphertext presented, held until out_ready
module aes_cipher_iter
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_load,
    input  logic [KEY_BITS-1:0] key,
    output logic                key_ready,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        datain,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        dataout,
    output logic                busy
);

    localparam int NK = nk_of(KEY_BITS);
    localparam int NR = nr_of(KEY_BITS);
    localparam int NW = 4 * (NR + 1);
    localparam logic [2:0] NK_M1  = 3'(NK - 1);
    localparam bit         IS_256 = (NK == 8);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_cipher_iter: KEY_BITS must be 128, 192 or 256");
    end

    aes_fsm_t   r_fsm, w_fsm_nxt;
    aes_word_t  r_rk [NW];
    aes_state_t r_blk, r_dout, w_rnd_out, w_rnd_key;
    logic [3:0] r_rnd;
    logic [5:0] r_widx;
    logic [2:0] r_kmod;
    logic [3:0] r_ridx;
    logic       r_key_ready;

    aes_word_t  w_prev, w_back, w_temp;
    logic [5:0] w_rk_base;
    logic       w_key_cap, w_data_acc, w_kexp_last, w_rnd_last, w_in_ready;

    assign w_in_ready  = (r_fsm == ST_IDLE) && r_key_ready && !key_load;
    assign w_kexp_last = (r_fsm == ST_KEXP) && (r_widx == 6'(NW - 1));
    assign w_rnd_last  = (r_fsm == ST_ROUND) && (r_rnd == 4'(NR));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm <= ST_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt  = r_fsm;
        w_key_cap  = 1'b0;
        w_data_acc = 1'b0;
        case (r_fsm)
            ST_IDLE: begin
                if (key_load) begin
                    w_key_cap = 1'b1;
                    w_fsm_nxt = ST_KEXP;
                end else if (in_valid && w_in_ready) begin
                    w_data_acc = 1'b1;
                    w_fsm_nxt  = ST_ROUND;
                end
            end
            ST_KEXP:  if (w_kexp_last) w_fsm_nxt = ST_IDLE;
            ST_ROUND: if (w_rnd_last)  w_fsm_nxt = ST_DONE;
            ST_DONE:  if (out_ready)   w_fsm_nxt = ST_IDLE;
            default:  w_fsm_nxt = ST_IDLE;
        endcase
    end

    // r_kmod tracks i % NK and r_ridx tracks i / NK, so no divider is needed.
    assign w_prev = r_rk[r_widx - 6'd1];
    assign w_back = r_rk[r_widx - 6'(NK)];

    always_comb begin
        w_temp = w_prev;
        if (r_kmod == 3'd0) begin
            w_temp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon(r_ridx), 24'h0};
        end else if (IS_256 && r_kmod == 3'd4) begin
            w_temp = sub_word(w_prev);
        end
    end

    // The store needs no reset: key_ready gates every use of it.
    always_ff @(posedge clk) begin
        if (w_key_cap) begin
            for (int k = 0; k < NK; k++) begin
                r_rk[k] <= key[KEY_BITS-1-32*k -: 32];
            end
        end else if (r_fsm == ST_KEXP) begin
            r_rk[r_widx] <= w_back ^ w_temp;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_widx      <= '0;
            r_kmod      <= '0;
            r_ridx      <= '0;
            r_key_ready <= 1'b0;
        end else if (w_key_cap) begin
            r_widx      <= 6'(NK);
            r_kmod      <= '0;
            r_ridx      <= 4'd1;
            r_key_ready <= 1'b0;
        end else if (r_fsm == ST_KEXP) begin
            r_widx <= r_widx + 6'd1;
            if (r_kmod == NK_M1) begin
                r_kmod <= '0;
                r_ridx <= r_ridx + 4'd1;
            end else begin
                r_kmod <= r_kmod + 3'd1;
            end
            if (w_kexp_last) begin
                r_key_ready <= 1'b1;
            end
        end
    end

    assign w_rk_base = {r_rnd, 2'b00};
    assign w_rnd_key = {r_rk[w_rk_base], r_rk[w_rk_base + 6'd1],
                        r_rk[w_rk_base + 6'd2], r_rk[w_rk_base + 6'd3]};

    aes_round u_round (
        .i_state (r_blk),
        .i_rkey  (w_rnd_key),
        .i_last  (w_rnd_last),
        .o_state (w_rnd_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blk  <= '0;
            r_rnd  <= '0;
            r_dout <= '0;
        end else if (w_data_acc) begin
            r_blk <= datain ^ {r_rk[0], r_rk[1], r_rk[2], r_rk[3]};
            r_rnd <= 4'd1;
        end else if (r_fsm == ST_ROUND) begin
            if (w_rnd_last) begin
                r_dout <= w_rnd_out;
            end else begin
                r_blk <= w_rnd_out;
                r_rnd <= r_rnd + 4'd1;
            end
        end
    end

    assign key_ready = r_key_ready;
    assign in_ready  = w_in_ready;
    assign out_valid = (r_fsm == ST_DONE);
    assign dataout   = r_dout;
    assign busy      = (r_fsm == ST_KEXP) || (r_fsm == ST_ROUND);

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Bench for aes_cipher_iter: one instance per key size, known-answer vectors pushed
// to a scoreboard at issue and popped by a monitor on each output handshake.
module tb_aes_cipher_iter;

    localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [191:0] K192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] KB   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT1  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT2  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PTB1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CTB1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PTB2 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CTB2 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

    typedef struct {
        int           u;
        logic [127:0] ct;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] key_all;
    logic [127:0] datain;
    logic [2:0]   kl, iv, ordy;
    logic [2:0]   kr, ir, ov, bsy;
    logic [127:0] dout [3];

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    aes_cipher_iter #(.KEY_BITS(128)) u_dut128 (
        .clk(clk), .rst(rst), .key_load(kl[0]), .key(key_all[255 -: 128]),
        .key_ready(kr[0]), .in_valid(iv[0]), .in_ready(ir[0]), .datain(datain),
        .out_valid(ov[0]), .out_ready(ordy[0]), .dataout(dout[0]), .busy(bsy[0])
    );

    aes_cipher_iter #(.KEY_BITS(192)) u_dut192 (
        .clk(clk), .rst(rst), .key_load(kl[1]), .key(key_all[255 -: 192]),
        .key_ready(kr[1]), .in_valid(iv[1]), .in_ready(ir[1]), .datain(datain),
        .out_valid(ov[1]), .out_ready(ordy[1]), .dataout(dout[1]), .busy(bsy[1])
    );

    aes_cipher_iter #(.KEY_BITS(256)) u_dut256 (
        .clk(clk), .rst(rst), .key_load(kl[2]), .key(key_all),
        .key_ready(kr[2]), .in_valid(iv[2]), .in_ready(ir[2]), .datain(datain),
        .out_valid(ov[2]), .out_ready(ordy[2]), .dataout(dout[2]), .busy(bsy[2])
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: a handshake is visible at the negedge before it completes.
    always @(negedge clk) begin
        if (!rst) begin
            for (int u = 0; u < 3; u++) begin
                if (ov[u] && ordy[u]) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_output", 128'(ov[u]), 128'd0);
                    end else begin
                        mon_e = sb_q.pop_front();
                        chk("ct_unit", 128'(u), 128'(mon_e.u));
                        chk("ciphertext", dout[u], mon_e.ct);
                    end
                end
            end
        end
    end

    task automatic load_key(input int u, input logic [255:0] k, input int lat);
        int n;
        n = 0;
        key_all = k;
        kl[u] = 1'b1;
        do begin
            tick();
            n++;
            if (bsy[u]) kl[u] = 1'b0;
        end while (!(kr[u] && !kl[u]) && n < 200);
        kl[u] = 1'b0;
        chk("key_latency", 128'(n), 128'(lat));
    endtask

    task automatic send(input int u, input logic [127:0] pt, input logic [127:0] ct,
                        input int lat, input int hold);
        int n;
        n = 0;
        ordy[u] = (hold == 0);
        while (!ir[u] && n < 100) begin
            tick();
            n++;
        end
        chk("in_ready_before_send", 128'(ir[u]), 128'd1);
        datain = pt;
        iv[u] = 1'b1;
        sb_q.push_back('{u, ct});
        tick();
        iv[u] = 1'b0;
        n = 0;
        while (!ov[u] && n < 100) begin
            tick();
            n++;
        end
        chk("data_latency", 128'(n), 128'(lat));
        for (int i = 0; i < hold; i++) begin
            chk("hold_dataout", dout[u], ct);
            chk("hold_in_ready", 128'(ir[u]), 128'd0);
            chk("hold_out_valid", 128'(ov[u]), 128'd1);
            tick();
        end
        ordy[u] = 1'b1;
        tick();
        chk("out_valid_drop", 128'(ov[u]), 128'd0);
        chk("in_ready_return", 128'(ir[u]), 128'd1);
    endtask

    task automatic chk_zero(input string nm, input int u);
        chk({nm, "_key_ready"}, 128'(kr[u]), 128'd0);
        chk({nm, "_in_ready"},  128'(ir[u]), 128'd0);
        chk({nm, "_out_valid"}, 128'(ov[u]), 128'd0);
        chk({nm, "_busy"},      128'(bsy[u]), 128'd0);
        chk({nm, "_dataout"},   dout[u], 128'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        kl = '0;
        iv = '0;
        ordy = '1;
        key_all = '0;
        datain = '0;
        repeat (3) tick();
        for (int u = 0; u < 3; u++) chk_zero("reset", u);
        rst = 1'b0;
        tick();

        // Known-answer vectors, one per key size
        load_key(0, {K128, 128'h0}, 41);
        send(0, PT, CT0, 10, 0);
        load_key(1, {K192, 64'h0}, 47);
        send(1, PT, CT1, 12, 0);
        load_key(2, K256, 53);
        send(2, PT, CT2, 14, 0);

        // Key reuse with 5 cycles of output backpressure
        load_key(0, {KB, 128'h0}, 41);
        send(0, PTB1, CTB1, 10, 5);
        send(0, PTB2, CTB2, 10, 5);

        // key_load and in_valid together: key wins, data is dropped
        key_all = {K128, 128'h0};
        datain = PT;
        kl[0] = 1'b1;
        iv[0] = 1'b1;
        tick();
        chk("collide_busy", 128'(bsy[0]), 128'd1);
        chk("collide_key_ready", 128'(kr[0]), 128'd0);
        kl[0] = 1'b0;
        iv[0] = 1'b0;
        n = 0;
        while (!kr[0] && n < 100) begin
            tick();
            n++;
        end
        chk("collide_kexp_len", 128'(n), 128'd40);

        // key_load pulsed during ROUND is ignored
        datain = PT;
        iv[0] = 1'b1;
        sb_q.push_back('{0, CT0});
        tick();
        iv[0] = 1'b0;
        key_all = {KB, 128'h0};
        kl[0] = 1'b1;
        repeat (3) tick();
        chk("kl_in_round_busy", 128'(bsy[0]), 128'd1);
        chk("kl_in_round_key_ready", 128'(kr[0]), 128'd1);
        kl[0] = 1'b0;
        n = 0;
        while (!ov[0] && n < 100) begin
            tick();
            n++;
        end
        chk("kl_in_round_latency", 128'(n), 128'd7);
        tick();
        chk("kl_in_round_in_ready", 128'(ir[0]), 128'd1);
        send(0, PT, CT0, 10, 0);

        // Reset in the middle of ROUND
        datain = PTB1;
        iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk_zero("rst_round", 0);
        tick();
        rst = 1'b0;
        iv[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_round_in_ready", 128'(ir[0]), 128'd0);
            chk("rst_round_busy", 128'(bsy[0]), 128'd0);
        end
        iv[0] = 1'b0;

        // Reset in the middle of KEXP
        key_all = {K128, 128'h0};
        kl[0] = 1'b1;
        tick();
        kl[0] = 1'b0;
        repeat (10) tick();
        chk("kexp_running", 128'(bsy[0]), 128'd1);
        rst = 1'b1;
        #1;
        chk_zero("rst_kexp", 0);
        tick();
        rst = 1'b0;
        iv[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_kexp_in_ready", 128'(ir[0]), 128'd0);
            chk("rst_kexp_key_ready", 128'(kr[0]), 128'd0);
        end
        iv[0] = 1'b0;

        load_key(0, {K128, 128'h0}, 41);
        send(0, PT, CT0, 10, 0);

        repeat (3) tick();
        chk("scoreboard_empty", 128'(sb_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
